pipe_hazard_ctrl: RTL and testbench
===================================

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255, max dmem wait cycles before error.
REQ-002 SHALL have parameter CNT_W, default 16, perf-counter width.
REQ-003 SHALL have ports: clk  in  1  rising-edge clock.
REQ-004 SHALL have ports: reset  in  1  asynchronous, active-low reset.
REQ-005 SHALL have ports: id_rs1, id_rs2  in  5 each  ID-stage source regs; id_use1, id_use2  in  1 each  source valid.
REQ-006 SHALL have ports: ex_rs1, ex_rs2, ex_rd  in  5 each  EX-stage regs; ex_mem_read  in  1  load in EX; ex_br_taken  in  1  branch/jump resolved taken in EX.
REQ-007 SHALL have ports: mem_rd  in  5, mem_reg_write  in  1; wb_rd  in  5, wb_reg_write  in  1.
REQ-008 SHALL have ports: dmem_req  in  1  MEM-stage access; dmem_ack  in  1  access complete.
REQ-009 SHALL have ports: pc_en, if_id_en, id_ex_en, ex_mem_en  out  1  stage enables; if_id_flush, id_ex_flush, mem_wb_flush  out  1  bubble inserts.
REQ-010 SHALL have ports: fwd_a, fwd_b  out  2  ALU operand select; state  out  2; err  out  1; stall_cnt, flush_cnt  out  CNT_W.

Function
REQ-011 SHALL implement FSM RUN=00, MWAIT=01, ERR=10; state output equals current state.
REQ-012 SHALL define freeze = dmem_req & !dmem_ack in RUN or MWAIT (combinational).
REQ-013 SHALL on freeze drive pc_en=if_id_en=id_ex_en=ex_mem_en=0, mem_wb_flush=1, all other flushes 0.
REQ-014 SHALL transition RUN->MWAIT on freeze; wait counter loads 1.
REQ-015 SHALL in MWAIT increment wait counter each frozen cycle; dmem_ack=1 -> RUN same edge, counter cleared.
REQ-016 SHALL transition MWAIT->ERR when wait counter equals TIMEOUT and dmem_ack=0.
REQ-017 SHALL in ERR hold all enables 0, all flushes 1, err=1; ERR exits only by reset.
REQ-018 SHALL define load-use = ex_mem_read & ex_rd!=0 & ((id_use1 & id_rs1==ex_rd) | (id_use2 & id_rs2==ex_rd)).
REQ-019 SHALL on load-use (no freeze, no branch) drive pc_en=0, if_id_en=0, id_ex_flush=1, other enables 1; one cycle only, no FSM change.
REQ-020 SHALL on ex_br_taken (no freeze) drive if_id_flush=1, id_ex_flush=1, pc_en=1; overrides load-use.
REQ-021 SHALL with no event drive all enables 1, all flushes 0.
REQ-022 SHALL ignore ex_br_taken while frozen; EX is held, so flush occurs on first unfrozen cycle.
REQ-023 SHALL set fwd_a=10 when mem_reg_write & mem_rd!=0 & mem_rd==ex_rs1; else 01 when wb_reg_write & wb_rd!=0 & wb_rd==ex_rs1; else 00; fwd_b same with ex_rs2; MEM priority over WB.
REQ-024 SHALL compute fwd_a/fwd_b combinationally in every state, independent of freeze.
REQ-025 SHALL increment stall_cnt on each cycle of freeze or load-use stall, saturating at all-ones.
REQ-026 SHALL increment flush_cnt on each cycle with if_id_flush=1 caused by ex_br_taken, saturating at all-ones.
REQ-027 SHALL register state, wait counter, err, stall_cnt, flush_cnt; all else combinational.

Reset
REQ-028 SHALL on reset=0 asynchronously force state=RUN, wait counter=0, err=0, stall_cnt=0, flush_cnt=0.
REQ-029 SHALL during reset and with idle inputs drive enables=1, flushes=0, fwd_a=fwd_b=00.
REQ-030 SHALL on reset assertion mid-MWAIT or in ERR return to RUN immediately, not waiting for a clock edge.

Verification
REQ-031 Load-use: ex_mem_read=1, ex_rd=5, id_rs1=5, id_use1=1 -> pc_en=0, if_id_en=0, id_ex_flush=1 one cycle, stall_cnt +1.
REQ-032 Branch+load-use same cycle: ex_br_taken=1 plus REQ-031 inputs -> pc_en=1, if_id_flush=1, id_ex_flush=1, flush_cnt +1, stall_cnt unchanged.
REQ-033 Forwarding: mem_rd=wb_rd=3, both write, ex_rs1=3, ex_rs2=0 -> fwd_a=10, fwd_b=00; mem_reg_write=0 -> fwd_a=01.
REQ-034 Memory wait: dmem_req=1, ack low 4 cycles then high -> state 00->01 for 4 cycles->00, enables 0 for 4 cycles, stall_cnt +4.
REQ-035 Timeout: TIMEOUT=3, dmem_req=1, ack never -> ERR after 3rd wait cycle, err=1 held; reset=0 -> state=00, err=0 without clock edge.
REQ-036 Saturation: CNT_W=4, 20 load-use cycles -> stall_cnt stays 15.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall, flush and forwarding control for a 5-stage pipe
// with dmem wait-state tracking, timeout trap and performance counters.
module pipe_hazard_ctrl #(
   parameter int TIMEOUT = 255,
   parameter int CNT_W   = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [4:0]       id_rs1,
   input  logic [4:0]       id_rs2,
   input  logic             id_use1,
   input  logic             id_use2,
   input  logic [4:0]       ex_rs1,
   input  logic [4:0]       ex_rs2,
   input  logic [4:0]       ex_rd,
   input  logic             ex_mem_read,
   input  logic             ex_br_taken,
   input  logic [4:0]       mem_rd,
   input  logic             mem_reg_write,
   input  logic [4:0]       wb_rd,
   input  logic             wb_reg_write,
   input  logic             dmem_req,
   input  logic             dmem_ack,
   output logic             pc_en,
   output logic             if_id_en,
   output logic             id_ex_en,
   output logic             ex_mem_en,
   output logic             if_id_flush,
   output logic             id_ex_flush,
   output logic             mem_wb_flush,
   output logic [1:0]       fwd_a,
   output logic [1:0]       fwd_b,
   output logic [1:0]       state,
   output logic             err,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   localparam int WW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {
      RUN   = 2'b00,
      MWAIT = 2'b01,
      ERR   = 2'b10
   } state_t;

   state_t          st;
   logic [WW-1:0]   wcnt;
   logic            in_err;
   logic            freeze;
   logic            hit1;
   logic            hit2;
   logic            lu;
   logic            br_fl;
   logic            lu_st;

   assign state  = st;
   assign in_err = (st == ERR);
   assign freeze = dmem_req & ~dmem_ack & ~in_err;

   assign hit1  = id_use1 & (id_rs1 == ex_rd);
   assign hit2  = id_use2 & (id_rs2 == ex_rd);
   assign lu    = ex_mem_read & (ex_rd != 5'd0) & (hit1 | hit2);
   assign br_fl = ex_br_taken & ~freeze & ~in_err;
   assign lu_st = lu & ~ex_br_taken & ~freeze & ~in_err;

   // MEM result is younger than WB, so it wins
   assign fwd_a =
      (mem_reg_write && mem_rd != 5'd0 && mem_rd == ex_rs1) ? 2'b10 :
      (wb_reg_write && wb_rd != 5'd0 && wb_rd == ex_rs1)    ? 2'b01 :
                                                              2'b00;
   assign fwd_b =
      (mem_reg_write && mem_rd != 5'd0 && mem_rd == ex_rs2) ? 2'b10 :
      (wb_reg_write && wb_rd != 5'd0 && wb_rd == ex_rs2)    ? 2'b01 :
                                                              2'b00;

   always_comb begin
      pc_en        = 1'b1;
      if_id_en     = 1'b1;
      id_ex_en     = 1'b1;
      ex_mem_en    = 1'b1;
      if_id_flush  = 1'b0;
      id_ex_flush  = 1'b0;
      mem_wb_flush = 1'b0;
      unique case (1'b1)
         in_err: begin
            pc_en        = 1'b0;
            if_id_en     = 1'b0;
            id_ex_en     = 1'b0;
            ex_mem_en    = 1'b0;
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
            mem_wb_flush = 1'b1;
         end
         freeze: begin
            pc_en        = 1'b0;
            if_id_en     = 1'b0;
            id_ex_en     = 1'b0;
            ex_mem_en    = 1'b0;
            mem_wb_flush = 1'b1;
         end
         br_fl: begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
         end
         lu_st: begin
            pc_en       = 1'b0;
            if_id_en    = 1'b0;
            id_ex_flush = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         st        <= RUN;
         wcnt      <= '0;
         err       <= 1'b0;
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         unique case (st)
            RUN: begin
               if (freeze) begin
                  st   <= MWAIT;
                  wcnt <= WW'(1);
               end
            end
            MWAIT: begin
               if (dmem_ack) begin
                  st   <= RUN;
                  wcnt <= '0;
               end else if (wcnt == WW'(TIMEOUT)) begin
                  st  <= ERR;
                  err <= 1'b1;
               end else if (freeze) begin
                  wcnt <= wcnt + WW'(1);
               end else begin
                  // request withdrawn without ack: nothing left to wait for
                  st   <= RUN;
                  wcnt <= '0;
               end
            end
            ERR: ;
            default: st <= ERR;
         endcase
         if ((freeze || lu_st) && stall_cnt != {CNT_W{1'b1}})
            stall_cnt <= stall_cnt + CNT_W'(1);
         if (br_fl && flush_cnt != {CNT_W{1'b1}})
            flush_cnt <= flush_cnt + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: two DUT instances (short timeout / narrow counters and
// defaults) driven by shared stimulus and checked against a behavioural model.
module tb_pipe_hazard_ctrl;

   logic       clk = 1'b0;
   logic       reset;
   logic [4:0] id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
   logic       id_use1, id_use2, ex_mem_read, ex_br_taken;
   logic       mem_reg_write, wb_reg_write, dmem_req, dmem_ack;

   logic        pc_en_a, if_id_en_a, id_ex_en_a, ex_mem_en_a;
   logic        if_id_flush_a, id_ex_flush_a, mem_wb_flush_a, err_a;
   logic [1:0]  fwd_a_a, fwd_b_a, state_a;
   logic [3:0]  stall_a, flush_a;

   logic        pc_en_b, if_id_en_b, id_ex_en_b, ex_mem_en_b;
   logic        if_id_flush_b, id_ex_flush_b, mem_wb_flush_b, err_b;
   logic [1:0]  fwd_a_b, fwd_b_b, state_b;
   logic [15:0] stall_b, flush_b;

   int nchk = 0;
   int nerr = 0;

   bit m_dead[2];
   int m_wait[2];
   int m_stall[2];
   int m_flush[2];

   always #5 clk = ~clk;

   pipe_hazard_ctrl #(.TIMEOUT(3), .CNT_W(4)) dut_a (
      .clk(clk), .reset(reset),
      .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_use1(id_use1), .id_use2(id_use2),
      .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
      .ex_mem_read(ex_mem_read), .ex_br_taken(ex_br_taken),
      .mem_rd(mem_rd), .mem_reg_write(mem_reg_write),
      .wb_rd(wb_rd), .wb_reg_write(wb_reg_write),
      .dmem_req(dmem_req), .dmem_ack(dmem_ack),
      .pc_en(pc_en_a), .if_id_en(if_id_en_a),
      .id_ex_en(id_ex_en_a), .ex_mem_en(ex_mem_en_a),
      .if_id_flush(if_id_flush_a), .id_ex_flush(id_ex_flush_a),
      .mem_wb_flush(mem_wb_flush_a),
      .fwd_a(fwd_a_a), .fwd_b(fwd_b_a), .state(state_a), .err(err_a),
      .stall_cnt(stall_a), .flush_cnt(flush_a)
   );

   pipe_hazard_ctrl dut_b (
      .clk(clk), .reset(reset),
      .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_use1(id_use1), .id_use2(id_use2),
      .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
      .ex_mem_read(ex_mem_read), .ex_br_taken(ex_br_taken),
      .mem_rd(mem_rd), .mem_reg_write(mem_reg_write),
      .wb_rd(wb_rd), .wb_reg_write(wb_reg_write),
      .dmem_req(dmem_req), .dmem_ack(dmem_ack),
      .pc_en(pc_en_b), .if_id_en(if_id_en_b),
      .id_ex_en(id_ex_en_b), .ex_mem_en(ex_mem_en_b),
      .if_id_flush(if_id_flush_b), .id_ex_flush(id_ex_flush_b),
      .mem_wb_flush(mem_wb_flush_b),
      .fwd_a(fwd_a_b), .fwd_b(fwd_b_b), .state(state_b), .err(err_b),
      .stall_cnt(stall_b), .flush_cnt(flush_b)
   );

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      nchk++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp,
                  $time);
      end
   endtask

   function automatic logic [6:0] ctl_a();
      return {pc_en_a, if_id_en_a, id_ex_en_a, ex_mem_en_a,
              if_id_flush_a, id_ex_flush_a, mem_wb_flush_a};
   endfunction

   function automatic logic [6:0] ctl_b();
      return {pc_en_b, if_id_en_b, id_ex_en_b, ex_mem_en_b,
              if_id_flush_b, id_ex_flush_b, mem_wb_flush_b};
   endfunction

   // {pc, if_id, id_ex, ex_mem enables, if_id, id_ex, mem_wb flushes}
   function automatic logic [6:0] exp_ctl(bit dead, bit frz, bit br, bit lu);
      if (dead) return 7'b0000_111;
      if (frz)  return 7'b0000_001;
      if (br)   return 7'b1111_110;
      if (lu)   return 7'b0011_010;
      return 7'b1111_000;
   endfunction

   function automatic logic [1:0] exp_fwd(logic [4:0] rs);
      if (mem_reg_write && mem_rd != 0 && mem_rd == rs) return 2'd2;
      if (wb_reg_write && wb_rd != 0 && wb_rd == rs) return 2'd1;
      return 2'd0;
   endfunction

   function automatic bit load_use();
      return ex_mem_read && ex_rd != 0 &&
             ((id_use1 && id_rs1 == ex_rd) || (id_use2 && id_rs2 == ex_rd));
   endfunction

   always @(negedge clk) begin : cmp
      logic [6:0]  ac;
      logic [1:0]  as, afa, afb;
      logic        ae;
      logic [15:0] ast, afl;
      int          tmo, mx, es;
      bit          frz, lu, br;
      for (int k = 0; k < 2; k++) begin
         tmo = (k == 0) ? 3 : 255;
         mx  = (k == 0) ? 15 : 65535;
         if (!reset) begin
            m_dead[k]  = 0;
            m_wait[k]  = 0;
            m_stall[k] = 0;
            m_flush[k] = 0;
         end
         if (k == 0) begin
            ac = ctl_a(); as = state_a; afa = fwd_a_a; afb = fwd_b_a;
            ae = err_a; ast = {12'd0, stall_a}; afl = {12'd0, flush_a};
         end else begin
            ac = ctl_b(); as = state_b; afa = fwd_a_b; afb = fwd_b_b;
            ae = err_b; ast = stall_b; afl = flush_b;
         end
         frz = !m_dead[k] && dmem_req && !dmem_ack;
         br  = !m_dead[k] && !frz && ex_br_taken;
         lu  = !m_dead[k] && !frz && !ex_br_taken && load_use();
         es  = m_dead[k] ? 2 : (m_wait[k] > 0 ? 1 : 0);
         chk($sformatf("ctl%0d", k), 32'(ac),
             32'(exp_ctl(m_dead[k], frz, br, lu)));
         chk($sformatf("state%0d", k), 32'(as), es);
         chk($sformatf("err%0d", k), 32'(ae), 32'(m_dead[k]));
         chk($sformatf("fwd_a%0d", k), 32'(afa), 32'(exp_fwd(ex_rs1)));
         chk($sformatf("fwd_b%0d", k), 32'(afb), 32'(exp_fwd(ex_rs2)));
         chk($sformatf("stall_cnt%0d", k), 32'(ast), m_stall[k]);
         chk($sformatf("flush_cnt%0d", k), 32'(afl), m_flush[k]);
         if (reset) begin
            if ((frz || lu) && m_stall[k] < mx) m_stall[k]++;
            if (br && m_flush[k] < mx) m_flush[k]++;
            if (!m_dead[k]) begin
               if (m_wait[k] == 0) begin
                  if (frz) m_wait[k] = 1;
               end else if (dmem_ack) begin
                  m_wait[k] = 0;
               end else if (m_wait[k] == tmo) begin
                  m_dead[k] = 1;
               end else if (dmem_req) begin
                  m_wait[k]++;
               end else begin
                  m_wait[k] = 0;
               end
            end
         end
      end
   end

   task automatic idle();
      id_rs1 = 0; id_rs2 = 0; id_use1 = 0; id_use2 = 0;
      ex_rs1 = 0; ex_rs2 = 0; ex_rd = 0;
      ex_mem_read = 0; ex_br_taken = 0;
      mem_rd = 0; mem_reg_write = 0; wb_rd = 0; wb_reg_write = 0;
      dmem_req = 0; dmem_ack = 0;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_lu();
      ex_mem_read = 1; ex_rd = 5; id_rs1 = 5; id_use1 = 1;
   endtask

   task automatic do_reset();
      step();
      reset = 0;
      idle();
      step();
      reset = 1;
   endtask

   initial begin : stim
      bit acc;
      int left;
      int dead_cyc;
      reset = 0;
      idle();
      #3;
      chk("rst_state", 32'(state_b), 0);
      chk("rst_ctl", 32'(ctl_b()), 32'(7'b1111_000));
      chk("rst_fwd", 32'({fwd_a_b, fwd_b_b}), 0);
      chk("rst_cnt", 32'(stall_b), 0);
      step();
      reset = 1;
      step();

      set_lu();
      #1 chk("lu_ctl", 32'(ctl_b()), 32'(7'b0011_010));
      step();
      idle();
      #1 chk("lu_stall", 32'(stall_b), 1);
      chk("lu_once", 32'(ctl_b()), 32'(7'b1111_000));

      set_lu();
      ex_br_taken = 1;
      #1 chk("br_ctl", 32'(ctl_b()), 32'(7'b1111_110));
      step();
      idle();
      #1 chk("br_flush", 32'(flush_b), 1);
      chk("br_stall", 32'(stall_b), 1);

      mem_rd = 3; wb_rd = 3; mem_reg_write = 1; wb_reg_write = 1;
      ex_rs1 = 3; ex_rs2 = 0;
      #1 chk("fwd_mem", 32'({fwd_a_b, fwd_b_b}), 32'(4'b1000));
      mem_reg_write = 0;
      #1 chk("fwd_wb", 32'(fwd_a_b), 1);
      mem_reg_write = 1; mem_rd = 0; wb_rd = 0; ex_rs1 = 0;
      #1 chk("fwd_x0", 32'(fwd_a_b), 0);

      step();
      idle();
      dmem_req = 1;
      #1 chk("mw_c1", 32'({state_b, ctl_b()}), 32'({2'd0, 7'b0000_001}));
      for (int i = 0; i < 3; i++) begin
         step();
         chk("mw_wait", 32'({state_b, ctl_b()}), 32'({2'd1, 7'b0000_001}));
      end
      step();
      dmem_ack = 1;
      #1 chk("mw_ack", 32'({state_b, ctl_b()}), 32'({2'd1, 7'b1111_000}));
      step();
      idle();
      #1 chk("mw_done", 32'(state_b), 0);
      chk("mw_stall", 32'(stall_b), 5);
      do_reset();

      idle();
      dmem_req = 1;
      repeat (4) step();
      chk("to_state", 32'(state_a), 2);
      chk("to_err", 32'(err_a), 1);
      chk("to_ctl", 32'(ctl_a()), 32'(7'b0000_111));
      step();
      chk("to_hold", 32'({state_a, err_a}), 32'(3'b101));
      step();
      #2;
      reset = 0;
      idle();
      #1 chk("to_async", 32'({state_a, err_a}), 0);
      chk("to_async_ctl", 32'(ctl_a()), 32'(7'b1111_000));
      step();
      reset = 1;

      set_lu();
      repeat (20) step();
      idle();
      #1 chk("sat_a", 32'(stall_a), 15);
      chk("sat_b", 32'(stall_b), 20);

      acc = 0;
      left = 0;
      dead_cyc = 0;
      for (int n = 0; n < 3000; n++) begin
         step();
         dead_cyc = m_dead[0] ? dead_cyc + 1 : 0;
         if ((dead_cyc > 2 && $urandom_range(3) == 0) ||
             $urandom_range(400) == 0) begin
            reset = 0;
            idle();
            acc = 0;
            continue;
         end
         reset = 1;
         id_rs1 = 5'($urandom_range(3));
         id_rs2 = 5'($urandom_range(3));
         id_use1 = 1'($urandom);
         id_use2 = 1'($urandom);
         ex_rs1 = 5'($urandom_range(3));
         ex_rs2 = 5'($urandom_range(3));
         ex_rd = 5'($urandom_range(3));
         ex_mem_read = ($urandom_range(2) == 0);
         ex_br_taken = ($urandom_range(4) == 0);
         mem_rd = 5'($urandom_range(3));
         wb_rd = 5'($urandom_range(3));
         mem_reg_write = 1'($urandom);
         wb_reg_write = 1'($urandom);
         if (!acc && $urandom_range(5) == 0) begin
            acc = 1;
            left = $urandom_range(5);
         end
         if (acc) begin
            dmem_req = 1;
            dmem_ack = (left == 0);
            if (left == 0) acc = 0;
            else left--;
         end else begin
            dmem_req = 0;
            dmem_ack = ($urandom_range(7) == 0);
         end
      end

      step();
      $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
      $finish;
   end

endmodule
